// File: rtl/lock_pkg.sv
// Shared types and defaults for the keypad lock response controller.
// States, default cycle counts, and the fail-counter width.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UNLOCK  = 2'd1,
        ALARM   = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_t;

    localparam int DEF_UNLOCK_CYCLES  = 50;
    localparam int DEF_ALARM_CYCLES   = 20;
    localparam int DEF_LOCKOUT_CYCLES = 200;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_CNT_W          = 8;
    localparam int FAIL_W             = 4;

    // Increment that holds at max instead of wrapping.
    function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v,
                                                  input int unsigned max);
        if (v >= FAIL_W'(max))
            return v;
        return v + FAIL_W'(1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the timed states; holds at zero.
module lock_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - CNT_W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lock_response_ctrl.sv
// Samples the code checker verdict on each enter press and drives the door
// unlock / buzzer, with a timed lockout after too many consecutive rejects.
module lock_response_ctrl
    import lock_pkg::*;
#(
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int ALARM_CYCLES   = DEF_ALARM_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              correct_signal,
    input  logic              alarm,
    input  logic              enter,
    output logic              unlock,
    output logic              buzzer,
    output logic              locked_out,
    output logic [FAIL_W-1:0] fail_count
);

    lock_state_t       state, state_nxt;
    logic [FAIL_W-1:0] fail_q, fail_nxt;
    logic              enter_q;
    logic              submit;
    logic              accept;
    logic              last_fail;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero;

    // Edge tracking runs in every state so a press begun while busy never fires later.
    assign submit    = enter & ~enter_q;
    assign accept    = correct_signal & ~alarm;
    assign last_fail = ({1'b0, fail_q} + (FAIL_W+1)'(1)) == (FAIL_W+1)'(MAX_FAILS);

    lock_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fail_q  <= '0;
            enter_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            fail_q  <= fail_nxt;
            enter_q <= enter;
        end
    end

    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE: begin
                if (submit) begin
                    tmr_load = 1'b1;
                    if (accept) begin
                        state_nxt = UNLOCK;
                        tmr_val   = CNT_W'(UNLOCK_CYCLES - 1);
                        fail_nxt  = '0;
                    end else if (last_fail) begin
                        state_nxt = LOCKOUT;
                        tmr_val   = CNT_W'(LOCKOUT_CYCLES - 1);
                        fail_nxt  = sat_inc(fail_q, MAX_FAILS);
                    end else begin
                        state_nxt = ALARM;
                        tmr_val   = CNT_W'(ALARM_CYCLES - 1);
                        fail_nxt  = sat_inc(fail_q, MAX_FAILS);
                    end
                end
            end
            UNLOCK, ALARM: begin
                if (tmr_zero)
                    state_nxt = IDLE;
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    state_nxt = IDLE;
                    fail_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on registered state.
    always_comb begin
        unlock     = 1'b0;
        buzzer     = 1'b0;
        locked_out = 1'b0;
        case (state)
            UNLOCK:  unlock = 1'b1;
            ALARM:   buzzer = 1'b1;
            LOCKOUT: begin
                buzzer     = 1'b1;
                locked_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign fail_count = fail_q;

endmodule
